// File: rtl/pc_fetch_ctrl.sv
// Purpose: fetch sequencer owning the PC; one instruction in flight, handed to decode one at a time.
// Latency: first imem_req 2 cycles after reset release; instr_valid the cycle after imem_ack; >= 3 cycles/instr.
// Backpressure: stall holds instr/pc/instr_valid; no new request is issued until decode consumes.
//
// Build option: define PC_FETCH_MISALIGN_TRAP_EN to turn a misaligned redirect target into a
// sticky fetch_err. Without it the low two target bits are simply cleared.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [16:0] TO_LIMIT  = 17'(TIMEOUT_CYC);

    state_t      state;
    logic [15:0] wait_cnt;
    logic [16:0] wait_cnt_inc;
    logic        pend;
    logic [31:0] pend_pc;
    logic [31:0] redir_tgt;
    logic        trap;

    // The address seen by memory is always the architectural PC.
    assign imem_addr = pc;

    // Redirect targets are word aligned before use.
    assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;

    // Widened so the timeout compare cannot overflow at the top of the range.
    assign wait_cnt_inc = {1'b0, wait_cnt} + 17'd1;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    // A misaligned target is fatal whenever a redirect would be accepted.
    assign trap = redirect && (redirect_pc[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    // Fetch sequencer: state, PC, request handshake, issued instruction and error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_VEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            fetch_err   <= 1'b0;
            pend        <= 1'b0;
            pend_pc     <= RESET_VEC;
            wait_cnt    <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                end

                FETCH: begin
                    if (trap) begin
                        state       <= ERR;
                        fetch_err   <= 1'b1;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b0;
                        wait_cnt    <= 16'd0;
                    end else begin
                        // A redirect seen while fetching becomes the pending target;
                        // the newest one wins.
                        if (redirect) begin
                            pend    <= 1'b1;
                            pend_pc <= redir_tgt;
                        end
                        if (!imem_req) begin
                            // One quiet cycle before every request.
                            imem_req <= 1'b1;
                            wait_cnt <= 16'd0;
                        end else if (imem_ack) begin
                            imem_req <= 1'b0;
                            wait_cnt <= 16'd0;
                            if (redirect || pend) begin
                                // Wrong-path word: drop it and refetch from the target.
                                pc   <= redirect ? redir_tgt : pend_pc;
                                pend <= 1'b0;
                            end else begin
                                instr       <= imem_rdata;
                                instr_valid <= 1'b1;
                                state       <= ISSUE;
                            end
                        end else if (wait_cnt_inc == TO_LIMIT) begin
                            state     <= ERR;
                            fetch_err <= 1'b1;
                            imem_req  <= 1'b0;
                            wait_cnt  <= wait_cnt_inc[15:0];
                        end else begin
                            wait_cnt <= wait_cnt_inc[15:0];
                        end
                    end
                end

                ISSUE: begin
                    if (trap) begin
                        state       <= ERR;
                        fetch_err   <= 1'b1;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b0;
                    end else if (!stall) begin
                        // Consume: a live redirect beats a recorded one, else fall through.
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                        pend        <= 1'b0;
                        if (redirect) begin
                            pc <= redir_tgt;
                        end else if (pend) begin
                            pc <= pend_pc;
                        end else begin
                            pc <= pc + 32'd4;
                        end
                    end else if (redirect) begin
                        pend    <= 1'b1;
                        pend_pc <= redir_tgt;
                    end
                end

                ERR: begin
                    // Sticky until reset; all outputs already parked.
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    fetch_err   <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios with literal expectations, then random traffic.
// A behavioural model in the bench predicts every output each cycle; outputs sampled on negedge.
// Memory responder reacts to imem_req with programmable or random latency.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam int          TO  = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.RESET_VEC(RV), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .pc(pc),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .fetch_err(fetch_err)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    int          mem_mode = 0;     // 0 fixed latency, 1 never acks, 2 random
    int          mem_lat = 1;
    int          cur_lat = 1;
    int          age = 0;
    logic        fixed_word = 1'b1;
    logic [31:0] fixed_val = 32'h0010_0093;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (fixed_word) return fixed_val;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    always @(negedge clk) begin
        if (imem_req === 1'b1) begin
            imem_ack = (mem_mode != 1) && (age >= cur_lat);
            age = age + 1;
        end else begin
            age = 0;
            imem_ack = (mem_mode == 2) && ($urandom_range(0, 7) == 0);
            if (mem_mode == 2)
                cur_lat = ($urandom_range(0, 19) == 0) ? 17 : int'($urandom_range(0, 3));
            else
                cur_lat = mem_lat;
        end
        imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
    end

    // ---------------- behavioural model ----------------
    // Tracks what the fetch unit must be doing: starting up, holding a word for decode,
    // waiting in the pre-request gap, or waiting on memory with a no-ack cycle count.
    logic [31:0] m_pc, m_instr, m_pend_pc;
    logic        m_req, m_valid, m_err, m_pend, m_boot;
    int          m_wait;

    task automatic model_step();
        logic [31:0] tgt;
        logic        trap;
        tgt = redirect_pc & 32'hFFFF_FFFC;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        trap = redirect && (redirect_pc[1:0] != 2'b00);
`else
        trap = 1'b0;
`endif
        if (rst !== 1'b1) begin
            m_pc = RV; m_instr = NOP; m_req = 0; m_valid = 0; m_err = 0;
            m_pend = 0; m_pend_pc = RV; m_wait = 0; m_boot = 1;
        end else if (m_err) begin
            // frozen until reset
        end else if (m_boot) begin
            m_boot = 0;
        end else if (trap) begin
            m_err = 1; m_req = 0; m_valid = 0;
        end else if (m_valid) begin
            if (!stall) begin
                m_pc = redirect ? tgt : (m_pend ? m_pend_pc : m_pc + 32'd4);
                m_pend = 0;
                m_valid = 0;
            end else if (redirect) begin
                m_pend = 1; m_pend_pc = tgt;
            end
        end else begin
            if (redirect) begin
                m_pend = 1; m_pend_pc = tgt;
            end
            if (!m_req) begin
                m_req = 1; m_wait = 0;
            end else if (imem_ack) begin
                m_req = 0; m_wait = 0;
                if (m_pend) begin
                    m_pc = m_pend_pc; m_pend = 0;
                end else begin
                    m_instr = imem_rdata; m_valid = 1;
                end
            end else begin
                m_wait = m_wait + 1;
                if (m_wait == TO) begin
                    m_err = 1; m_req = 0;
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    // Single compare process: every output against the model, every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check1 ("mdl_req",   imem_req,    m_req);
            check32("mdl_addr",  imem_addr,   m_pc);
            check1 ("mdl_valid", instr_valid, m_valid);
            check32("mdl_instr", instr,       m_instr);
            check32("mdl_pc",    pc,          m_pc);
            check1 ("mdl_err",   fetch_err,   m_err);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_req(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (imem_req !== 1'b1 && n < 60);
        check1(tag, imem_req, 1'b1);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (instr_valid !== 1'b1 && n < 60);
        check1(tag, instr_valid, 1'b1);
    endtask

    task automatic pulse_redirect(input logic [31:0] tgt);
        redirect = 1'b1;
        redirect_pc = tgt;
        @(negedge clk);
        redirect = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int errcyc;
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        // Reset state
        check1 ("rst_req",   imem_req, 1'b0);
        check1 ("rst_valid", instr_valid, 1'b0);
        check32("rst_instr", instr, NOP);
        check32("rst_pc",    pc, RV);
        check1 ("rst_err",   fetch_err, 1'b0);

        // Boot timing with memory acking one cycle after it sees the request
        rst = 1'b1;
        @(negedge clk); check1("boot_c1_req", imem_req, 1'b0);
        @(negedge clk); check1("boot_c2_req", imem_req, 1'b1);
                        check32("boot_c2_addr", imem_addr, 32'h0);
        @(negedge clk); check1("boot_c3_valid", instr_valid, 1'b0);
        @(negedge clk); check1("boot_c4_valid", instr_valid, 1'b1);
                        check32("boot_c4_instr", instr, 32'h0010_0093);
                        check32("boot_c4_pc", pc, 32'h0);
        wait_req("seq_req4");
        check32("seq_addr4", imem_addr, 32'h4);

        // Stall for 5 cycles on the word at pc 8
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(instr_valid === 1'b1 && pc === 32'h8) && n < 60);
        check32("stall_pc8", pc, 32'h8);
        stall = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check1 ("stall_valid", instr_valid, 1'b1);
            check32("stall_pc",    pc, 32'h8);
            check32("stall_instr", instr, 32'h0010_0093);
            check1 ("stall_noreq", imem_req, 1'b0);
        end
        stall = 1'b0;
        wait_req("stall_rel_req");
        check32("stall_rel_addr", imem_addr, 32'hC);

        // Redirect while memory takes 3 extra cycles
        mem_lat = 3;
        wait_valid("rd_prev_valid");
        wait_req("rd_req");
        check32("rd_req_addr", imem_addr, 32'h10);
        pulse_redirect(32'h0000_0100);
        n = 0;
        while (imem_req === 1'b1 && n < 20) begin
            check1("rd_no_valid", instr_valid, 1'b0);
            @(negedge clk);
            n++;
        end
        check1 ("rd_gap_req", imem_req, 1'b0);
        check1 ("rd_gap_valid", instr_valid, 1'b0);
        check32("rd_gap_pc", pc, 32'h100);
        @(negedge clk);
        check1 ("rd_new_req", imem_req, 1'b1);
        check32("rd_new_addr", imem_addr, 32'h100);

        // Wrap: redirect to the top word, consume, next fetch at 0
        mem_lat = 0;
        wait_valid("wr_prev_valid");
        wait_req("wr_req");
        pulse_redirect(32'hFFFF_FFFC);
        wait_valid("wr_valid");
        check32("wr_pc", pc, 32'hFFFF_FFFC);
        wait_req("wr_next_req");
        check32("wr_next_addr", imem_addr, 32'h0);

        // Misaligned redirect target
        wait_req("mis_req");
        check32("mis_req_addr", imem_addr, 32'h4);
        pulse_redirect(32'h0000_0102);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        check1("mis_err", fetch_err, 1'b1);
        check1("mis_req_drop", imem_req, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check1("mis_no_fetch", imem_req, 1'b0);
            check1("mis_err_hold", fetch_err, 1'b1);
        end
`else
        check1 ("mis_gap_req", imem_req, 1'b0);
        check32("mis_pc", pc, 32'h100);
        @(negedge clk);
        check1 ("mis_new_req", imem_req, 1'b1);
        check32("mis_new_addr", imem_addr, 32'h100);
        check1 ("mis_no_err", fetch_err, 1'b0);
`endif

        // Timeout: memory stops acking on the fetch at pc 4
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wait_valid("to_first_valid");
        mem_mode = 1;
        wait_req("to_req");
        check32("to_req_addr", imem_addr, 32'h4);
        n = 0;
        while (imem_req === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check32("to_req_cycles", n, 32'd16);
        check1 ("to_err", fetch_err, 1'b1);
        check1 ("to_req_low", imem_req, 1'b0);
        repeat (4) begin
            @(negedge clk);
            check1 ("to_err_sticky", fetch_err, 1'b1);
            check32("to_pc_frozen", pc, 32'h4);
            check1 ("to_req_stays_low", imem_req, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        check32("to_rst_pc", pc, RV);
        check1 ("to_rst_err", fetch_err, 1'b0);

        // Random traffic against the model
        rst = 1'b1;
        mem_mode = 2;
        fixed_word = 1'b0;
        errcyc = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            stall = ($urandom_range(0, 2) == 0);
            redirect = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 7))
                0: redirect_pc = 32'hFFFF_FFFC;
                1: redirect_pc = $urandom;
                default: redirect_pc = $urandom & 32'h0000_FFFC;
            endcase
            errcyc = m_err ? errcyc + 1 : 0;
            if (rst == 1'b0) rst = 1'b1;
            else if (errcyc > 4 || $urandom_range(0, 399) == 0) rst = 1'b0;
        end
        rst = 1'b1;
        redirect = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
